// File: rtl/clock_monitor.sv
// ---------------------------------------------------------------------------
// clock_monitor
//
// Checks a generated clock. The free-running clk samples mon_clk, and each
// mon_clk period and high time is measured in clk cycles. The block flags
// out-of-range periods, out-of-range high times and a stuck clock, and it
// reports lock once enough consecutive good periods have been seen.
//
// Parameters
//   CNT_W     width of the period/high counters and the measurement outputs
//   LOCK_CNT  consecutive good measurements needed to assert locked (>= 1)
//   TIMEOUT   clk cycles without a mon_clk rise before stuck_err (< 2^CNT_W)
//
// Ports
//   clk          sampling clock, at least 4x the mon_clk frequency
//   rst_n        asynchronous active-low reset
//   mon_clk      monitored clock, asynchronous to clk
//   enable       1 = monitoring active
//   per_min/max  inclusive legal period range (clk cycles)
//   hi_min/max   inclusive legal high-time range (clk cycles)
//   err_clr      one-cycle pulse; clears the sticky flags and err_cnt
//   meas_valid   one-cycle pulse; new period_meas/high_meas available
//   period_meas  last measured period
//   high_meas    last measured high time
//   period_err   sticky: a period was out of range
//   duty_err     sticky: a high time was out of range
//   stuck_err    sticky: no mon_clk rise for TIMEOUT cycles
//   err_cnt      bad measurements plus timeouts, saturating at 16'hFFFF
//   locked       LOCK_CNT consecutive good measurements seen
// ---------------------------------------------------------------------------
module clock_monitor #(
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mon_clk,
    input  logic             enable,
    input  logic [CNT_W-1:0] per_min,
    input  logic [CNT_W-1:0] per_max,
    input  logic [CNT_W-1:0] hi_min,
    input  logic [CNT_W-1:0] hi_max,
    input  logic             err_clr,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_meas,
    output logic [CNT_W-1:0] high_meas,
    output logic             period_err,
    output logic             duty_err,
    output logic             stuck_err,
    output logic [15:0]      err_cnt,
    output logic             locked
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;

    localparam int               GOOD_W    = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0] LOCK_V   = GOOD_W'(LOCK_CNT);
    localparam logic [GOOD_W-1:0] GOOD_ONE = GOOD_W'(1);
    localparam logic [15:0]      ERR_MAX   = 16'hFFFF;

    // Saturating increment for the period/high counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    logic              r_sync1;
    logic              r_s_q;
    logic              r_prev_q;
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_per_cnt;
    logic [CNT_W-1:0]  r_hi_cnt;
    logic              r_to_fired;
    logic [GOOD_W-1:0] r_good_cnt;

    logic              w_rise;
    logic              w_run;
    logic              w_capture;
    logic              w_per_bad;
    logic              w_hi_bad;
    logic              w_meas_bad;
    logic              w_meas_good;
    logic              w_timeout;
    logic              w_new_err;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_per_nxt;
    logic [CNT_W-1:0]  w_hi_nxt;
    logic              w_to_fired_nxt;
    logic [GOOD_W-1:0] w_good_nxt;
    logic [15:0]       w_cnt_base;
    logic [15:0]       w_cnt_nxt;

    assign w_rise      = r_s_q & ~r_prev_q;
    // Counters only run while enabled in an active state; enable falling
    // zeroes them, so a truncated period is never reported.
    assign w_run       = enable & ((r_state == ST_WAIT) | (r_state == ST_MEAS));
    assign w_capture   = w_run & (r_state == ST_MEAS) & w_rise;
    // Counter values are the pre-load values, i.e. the completed period.
    assign w_per_bad   = (r_per_cnt < per_min) | (r_per_cnt > per_max);
    assign w_hi_bad    = (r_hi_cnt < hi_min) | (r_hi_cnt > hi_max);
    assign w_meas_bad  = w_capture & (w_per_bad | w_hi_bad);
    assign w_meas_good = w_capture & ~(w_per_bad | w_hi_bad);
    // r_to_fired keeps one stuck episode from being counted twice.
    assign w_timeout   = w_run & ~w_rise & ~r_to_fired & (r_per_cnt == TIMEOUT_V);
    assign w_new_err   = w_meas_bad | w_timeout;

    // Next-state selection for the IDLE / WAIT_EDGE / MEASURE controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rise) begin
                    w_state_nxt = ST_MEAS;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_MEAS: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_MEAS;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values for the period/high counters and the timeout latch.
    always_comb begin
        w_per_nxt      = r_per_cnt;
        w_hi_nxt       = r_hi_cnt;
        w_to_fired_nxt = r_to_fired;
        if (!w_run) begin
            w_per_nxt      = '0;
            w_hi_nxt       = '0;
            w_to_fired_nxt = 1'b0;
        end else if (w_rise) begin
            w_per_nxt      = CNT_ONE;
            w_hi_nxt       = CNT_ONE;
            w_to_fired_nxt = 1'b0;
        end else begin
            w_per_nxt = sat_inc(r_per_cnt);
            if (r_s_q) begin
                w_hi_nxt = sat_inc(r_hi_cnt);
            end else begin
                w_hi_nxt = r_hi_cnt;
            end
            if (w_timeout) begin
                w_to_fired_nxt = 1'b1;
            end else begin
                w_to_fired_nxt = r_to_fired;
            end
        end
    end

    // Next values for the good-measurement run length and the error counter.
    always_comb begin
        w_good_nxt = r_good_cnt;
        if (!w_run || w_new_err) begin
            w_good_nxt = '0;
        end else if (w_meas_good && (r_good_cnt != LOCK_V)) begin
            w_good_nxt = r_good_cnt + GOOD_ONE;
        end else begin
            w_good_nxt = r_good_cnt;
        end

        // A clear coinciding with a new error leaves exactly that one error.
        if (err_clr) begin
            w_cnt_base = 16'h0000;
        end else begin
            w_cnt_base = err_cnt;
        end
        if (w_new_err && (w_cnt_base != ERR_MAX)) begin
            w_cnt_nxt = w_cnt_base + 16'h0001;
        end else begin
            w_cnt_nxt = w_cnt_base;
        end
    end

    // mon_clk synchronizer and previous-sample register for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_s_q    <= 1'b0;
            r_prev_q <= 1'b0;
        end else begin
            r_sync1  <= mon_clk;
            r_s_q    <= r_sync1;
            r_prev_q <= r_s_q;
        end
    end

    // Controller state, counters and lock tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_per_cnt  <= '0;
            r_hi_cnt   <= '0;
            r_to_fired <= 1'b0;
            r_good_cnt <= '0;
            locked     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_per_cnt  <= w_per_nxt;
            r_hi_cnt   <= w_hi_nxt;
            r_to_fired <= w_to_fired_nxt;
            r_good_cnt <= w_good_nxt;
            locked     <= (w_good_nxt == LOCK_V);
        end
    end

    // Measurement capture and the valid strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid  <= 1'b0;
            period_meas <= '0;
            high_meas   <= '0;
        end else begin
            meas_valid <= w_capture;
            if (w_capture) begin
                period_meas <= r_per_cnt;
                high_meas   <= r_hi_cnt;
            end else begin
                period_meas <= period_meas;
                high_meas   <= high_meas;
            end
        end
    end

    // Sticky error flags and the error counter; a new error wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_err <= 1'b0;
            duty_err   <= 1'b0;
            stuck_err  <= 1'b0;
            err_cnt    <= 16'h0000;
        end else begin
            period_err <= (period_err & ~err_clr) | (w_capture & w_per_bad);
            duty_err   <= (duty_err & ~err_clr) | (w_capture & w_hi_bad);
            stuck_err  <= (stuck_err & ~err_clr) | w_timeout;
            err_cnt    <= w_cnt_nxt;
        end
    end

endmodule
